// File: rtl/rob_nway.sv
// rob_nway: N-way reorder buffer with in-order multi-slot dispatch, CDB completion and in-order retire.
// Define ROB_CDB_BYPASS_EN to let a same-cycle CDB completion make head entries retirable.
module rob_nway #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned DP_WIDTH  = 2,
  parameter int unsigned RT_WIDTH  = 2,
  parameter int unsigned CDB_WIDTH = 2,
  parameter int unsigned REG_IDX_W = 5,
  localparam int unsigned TAG_W    = $clog2(DEPTH),
  localparam int unsigned FS_W     = $clog2(DP_WIDTH) + 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DP_WIDTH-1:0]           dp_valid,
  input  logic [DP_WIDTH*REG_IDX_W-1:0] dp_dest_reg,
  output logic [DP_WIDTH*TAG_W-1:0]     dp_tag,
  output logic [FS_W-1:0]               dp_free_slots,
  input  logic [CDB_WIDTH-1:0]          cdb_valid,
  input  logic [CDB_WIDTH*TAG_W-1:0]    cdb_tag,
  input  logic [CDB_WIDTH-1:0]          cdb_mispredict,
  output logic [RT_WIDTH-1:0]           rt_valid,
  output logic [RT_WIDTH*REG_IDX_W-1:0] rt_dest_reg,
  output logic [RT_WIDTH*TAG_W-1:0]     rt_tag,
  output logic                          squash,
  output logic                          full,
  output logic                          empty
);
  localparam int unsigned CNT_W = TAG_W + 1;

  logic [DEPTH-1:0]              r_valid;
  logic [DEPTH-1:0]              r_complete;
  logic [DEPTH-1:0]              r_mispred;
  logic [REG_IDX_W-1:0]          r_dest [DEPTH];
  logic [TAG_W-1:0]              r_head;
  logic [TAG_W-1:0]              r_tail;
  logic [CNT_W-1:0]              r_count;
  logic [RT_WIDTH-1:0]           r_rt_valid;
  logic [RT_WIDTH*REG_IDX_W-1:0] r_rt_dest;
  logic [RT_WIDTH*TAG_W-1:0]     r_rt_tag;
  logic                          r_squash;

  logic [CNT_W-1:0]    w_free;
  logic [FS_W-1:0]     w_free_slots;
  logic [CNT_W-1:0]    w_req_cnt;
  logic [CNT_W-1:0]    w_dp_cnt;
  logic [DP_WIDTH-1:0] w_dp_acc;
  logic [TAG_W-1:0]    w_dp_idx [DP_WIDTH];
  logic [CNT_W-1:0]    w_rt_cnt;
  logic [RT_WIDTH-1:0] w_rt_fire;
  logic [TAG_W-1:0]    w_rt_idx [RT_WIDTH];
  logic [RT_WIDTH-1:0] w_bp_cmp;
  logic [RT_WIDTH-1:0] w_bp_mp;
  logic                w_flush;
  logic                w_stop;

  // Free slots come from the registered count, so same-cycle retirement never adds room.
  always_comb begin
    w_free       = CNT_W'(DEPTH) - r_count;
    w_free_slots = (w_free < CNT_W'(DP_WIDTH)) ? FS_W'(w_free) : FS_W'(DP_WIDTH);
  end

  // Dispatch acceptance: contiguous slots from 0, clipped to the free-slot count.
  always_comb begin
    w_dp_acc  = '0;
    w_req_cnt = '0;
    w_dp_cnt  = '0;
    for (int i = 0; i < DP_WIDTH; i++) begin
      w_dp_idx[i] = r_tail + TAG_W'(i);
      if (dp_valid[i]) begin
        w_req_cnt = w_req_cnt + CNT_W'(1);
        if (FS_W'(i) < w_free_slots) begin
          w_dp_acc[i] = 1'b1;
          w_dp_cnt    = w_dp_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Retire scan: consecutive completed entries from head; a mispredict retires and stops the scan.
  always_comb begin
    w_bp_cmp  = '0;
    w_bp_mp   = '0;
    w_rt_fire = '0;
    w_rt_cnt  = '0;
    w_flush   = 1'b0;
    w_stop    = 1'b0;
    for (int j = 0; j < RT_WIDTH; j++) begin
      w_rt_idx[j] = r_head + TAG_W'(j);
`ifdef ROB_CDB_BYPASS_EN
      for (int l = 0; l < CDB_WIDTH; l++) begin
        if (cdb_valid[l] && (cdb_tag[l*TAG_W +: TAG_W] == w_rt_idx[j])) begin
          w_bp_cmp[j] = 1'b1;
          w_bp_mp[j]  = w_bp_mp[j] | cdb_mispredict[l];
        end
      end
`endif
      if (!w_stop && r_valid[w_rt_idx[j]] && (r_complete[w_rt_idx[j]] || w_bp_cmp[j])) begin
        w_rt_fire[j] = 1'b1;
        w_rt_cnt     = w_rt_cnt + CNT_W'(1);
        if (r_mispred[w_rt_idx[j]] || w_bp_mp[j]) begin
          w_flush = 1'b1;
          w_stop  = 1'b1;
        end
      end else begin
        w_stop = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid    <= '0;
      r_complete <= '0;
      r_mispred  <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_rt_valid <= '0;
      r_rt_dest  <= '0;
      r_rt_tag   <= '0;
      r_squash   <= 1'b0;
    end else begin
      for (int l = 0; l < CDB_WIDTH; l++) begin
        if (cdb_valid[l] && r_valid[cdb_tag[l*TAG_W +: TAG_W]]) begin
          r_complete[cdb_tag[l*TAG_W +: TAG_W]] <= 1'b1;
          if (cdb_mispredict[l]) r_mispred[cdb_tag[l*TAG_W +: TAG_W]] <= 1'b1;
        end
      end
      for (int j = 0; j < RT_WIDTH; j++) begin
        if (w_rt_fire[j]) begin
          r_valid[w_rt_idx[j]]    <= 1'b0;
          r_complete[w_rt_idx[j]] <= 1'b0;
          r_mispred[w_rt_idx[j]]  <= 1'b0;
        end
        r_rt_valid[j]                       <= w_rt_fire[j];
        r_rt_dest[j*REG_IDX_W +: REG_IDX_W] <= r_dest[w_rt_idx[j]];
        r_rt_tag[j*TAG_W +: TAG_W]          <= w_rt_idx[j];
      end
      // A flush wipes every surviving entry and drops this cycle's dispatch.
      if (w_flush) begin
        r_valid    <= '0;
        r_complete <= '0;
        r_mispred  <= '0;
        r_tail     <= r_head + TAG_W'(w_rt_cnt);
        r_count    <= '0;
      end else begin
        for (int i = 0; i < DP_WIDTH; i++) begin
          if (w_dp_acc[i]) begin
            r_valid[w_dp_idx[i]]    <= 1'b1;
            r_complete[w_dp_idx[i]] <= 1'b0;
            r_mispred[w_dp_idx[i]]  <= 1'b0;
          end
        end
        r_tail  <= r_tail + TAG_W'(w_dp_cnt);
        r_count <= r_count + w_dp_cnt - w_rt_cnt;
      end
      r_head   <= r_head + TAG_W'(w_rt_cnt);
      r_squash <= w_flush;
    end
  end

  // Destination payload needs no reset; it is only observed behind a valid bit.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DP_WIDTH; i++) begin
      if (!reset && !w_flush && w_dp_acc[i]) r_dest[w_dp_idx[i]] <= dp_dest_reg[i*REG_IDX_W +: REG_IDX_W];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (w_req_cnt <= CNT_W'(w_free_slots))
        else $error("rob_nway: dispatch request count exceeds free slots");
    end
  end

  always_comb begin
    for (int i = 0; i < DP_WIDTH; i++) dp_tag[i*TAG_W +: TAG_W] = w_dp_idx[i];
  end

  assign dp_free_slots = w_free_slots;
  assign rt_valid      = r_rt_valid;
  assign rt_dest_reg   = r_rt_dest;
  assign rt_tag        = r_rt_tag;
  assign squash        = r_squash;
  assign full          = (r_count == CNT_W'(DEPTH));
  assign empty         = (r_count == '0);

endmodule
